// File: rtl/riscv_branch_pkg.sv
// rtl/riscv_branch_pkg.sv - shared branch funct3 codes, PC-unit state type and default parameters
// Contents: XLEN_DEF, RESET_PC_DEF, TRAP_VEC_DEF, F3_* branch encodings, state_t.
package riscv_branch_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    TRAP  = 2'd3
  } state_t;

endpackage

// File: rtl/branch_compare.sv
// rtl/branch_compare.sv - combinational branch condition resolver
// Ports: funct3 (branch kind), rs1/rs2 (operands), taken (condition holds).
module branch_compare
  import riscv_branch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      // 010/011 are not branch encodings: never taken, so no flush or trap follows.
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - fetch PC sequencing, taken-branch redirect/flush and misaligned-target trap
// Ports: Clock, Reset_n (async active-low); pc_out/pc_valid/fetch_ready (fetch side);
// br_valid/br_ready/br_funct3/br_rs1/br_rs2/br_pc/immediate_branch_in (execute side);
// flush/taken_out/misaligned_trap (one-cycle pulses); trap_pc/trap_ack (trap handshake).
module branch_pc_unit
  import riscv_branch_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC     = XLEN'(RESET_PC_DEF),
  parameter logic [XLEN-1:0] TRAP_VEC     = XLEN'(TRAP_VEC_DEF),
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            Clock,
  input  logic            Reset_n,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  input  logic            fetch_ready,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_funct3,
  input  logic [XLEN-1:0] br_rs1,
  input  logic [XLEN-1:0] br_rs2,
  input  logic [XLEN-1:0] br_pc,
  input  logic [12:0]     immediate_branch_in,
  output logic            flush,
  output logic            taken_out,
  output logic            misaligned_trap,
  output logic [XLEN-1:0] trap_pc,
  input  logic            trap_ack
);

  localparam int              CNT_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   pc_d, trap_pc_d;
  logic              flush_d, taken_d, mis_d;
  logic              br_taken;
  logic              accept;
  logic [12:0]       imm_even;
  logic [XLEN-1:0]   target;

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .funct3 (br_funct3),
    .rs1    (br_rs1),
    .rs2    (br_rs2),
    .taken  (br_taken)
  );

  // Bit 0 of the B-type immediate is architecturally zero; force it rather than trust decode.
  assign imm_even = immediate_branch_in & 13'h1FFE;
  assign target   = br_pc + {{(XLEN-13){imm_even[12]}}, imm_even};
  assign accept   = br_valid & br_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc_out;
    trap_pc_d = trap_pc;
    flush_d   = 1'b0;
    taken_d   = 1'b0;
    mis_d     = 1'b0;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        // A taken branch overrides the sequential increment in the same cycle.
        if (accept && br_taken) begin
          taken_d = 1'b1;
          flush_d = 1'b1;
          if (target[1]) begin
            mis_d     = 1'b1;
            trap_pc_d = br_pc;
            state_d   = TRAP;
          end else begin
            pc_d    = target;
            cnt_d   = '0;
            state_d = FLUSH;
          end
        end else if (fetch_ready) begin
          pc_d = pc_out + XLEN'(4);
        end
      end
      FLUSH: begin
        if (cnt_q == CNT_LAST) state_d = RUN;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      TRAP: begin
        if (trap_ack) begin
          pc_d      = TRAP_VEC;
          trap_pc_d = '0;
          state_d   = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      pc_out          <= RESET_PC;
      pc_valid        <= 1'b0;
      br_ready        <= 1'b0;
      flush           <= 1'b0;
      taken_out       <= 1'b0;
      misaligned_trap <= 1'b0;
      trap_pc         <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pc_out          <= pc_d;
      // Handshake outputs are registered copies of "next state is RUN".
      pc_valid        <= (state_d == RUN);
      br_ready        <= (state_d == RUN);
      flush           <= flush_d;
      taken_out       <= taken_d;
      misaligned_trap <= mis_d;
      trap_pc         <= trap_pc_d;
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - self-checking bench for branch_pc_unit
module tb_branch_pc_unit;
  import riscv_branch_pkg::*;

  localparam int FC = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        fetch_ready = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_ready;
  logic [2:0]  br_funct3 = 3'b000;
  logic [31:0] br_rs1 = '0, br_rs2 = '0, br_pc = '0;
  logic [12:0] immediate_branch_in = '0;
  logic        flush, taken_out, misaligned_trap;
  logic [31:0] trap_pc;
  logic        trap_ack = 1'b0;

  int n_assert = 0;
  int n_fail = 0;

  // Reference model state
  bit          m_idle;
  bit          m_trap;
  int          m_bubbles;
  logic [31:0] m_pc, m_trap_pc;
  bit          e_flush, e_taken, e_mis;

  branch_pc_unit #(.FLUSH_CYCLES(FC)) dut (
    .Clock               (clock),
    .Reset_n             (reset_n),
    .pc_out              (pc_out),
    .pc_valid            (pc_valid),
    .fetch_ready         (fetch_ready),
    .br_valid            (br_valid),
    .br_ready            (br_ready),
    .br_funct3           (br_funct3),
    .br_rs1              (br_rs1),
    .br_rs2              (br_rs2),
    .br_pc               (br_pc),
    .immediate_branch_in (immediate_branch_in),
    .flush               (flush),
    .taken_out           (taken_out),
    .misaligned_trap     (misaligned_trap),
    .trap_pc             (trap_pc),
    .trap_ack            (trap_ack)
  );

  always #5 clock = ~clock;

  function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (f3)
      3'd0: return ua == ub;
      3'd1: return ua != ub;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return ua < ub;
      3'd7: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [12:0] imm);
    longint off, t;
    off = longint'(imm) & 64'h1FFE;
    if (off >= 4096) off = off - 8192;
    t = (longint'(pc) + off) % 64'h1_0000_0000;
    if (t < 0) t = t + 64'h1_0000_0000;
    return t[31:0];
  endfunction

  task automatic model_reset();
    m_idle = 1; m_trap = 0; m_bubbles = 0;
    m_pc = 32'h0; m_trap_pc = 32'h0;
    e_flush = 0; e_taken = 0; e_mis = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_edge();
    logic [31:0] t;
    e_flush = 0; e_taken = 0; e_mis = 0;
    if (m_idle) begin
      m_idle = 0;
    end else if (m_trap) begin
      if (trap_ack) begin
        m_trap = 0; m_pc = 32'h100; m_trap_pc = 0;
      end
    end else if (m_bubbles > 0) begin
      m_bubbles = m_bubbles - 1;
    end else if (br_valid && ref_taken(br_funct3, br_rs1, br_rs2)) begin
      t = ref_target(br_pc, immediate_branch_in);
      e_flush = 1; e_taken = 1;
      if ((t / 2) % 2 == 1) begin
        e_mis = 1; m_trap = 1; m_trap_pc = br_pc;
      end else begin
        m_pc = t; m_bubbles = FC;
      end
    end else if (fetch_ready) begin
      m_pc = 32'((longint'(m_pc) + 4) % 64'h1_0000_0000);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    bit v;
    v = !m_idle && !m_trap && (m_bubbles == 0);
    check("pc_out", pc_out, m_pc);
    check("pc_valid", 32'(pc_valid), 32'(v));
    check("br_ready", 32'(br_ready), 32'(v));
    check("flush", 32'(flush), 32'(e_flush));
    check("taken_out", 32'(taken_out), 32'(e_taken));
    check("misaligned_trap", 32'(misaligned_trap), 32'(e_mis));
    check("trap_pc", trap_pc, m_trap_pc);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [12:0] imm);
    br_funct3 = f3; br_rs1 = a; br_rs2 = b; br_pc = pc; immediate_branch_in = imm;
    br_valid = 1'b1;
    tick();
    br_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all();
    check("reset_state", 32'(dut.state_q), 32'(IDLE));

    // Release reset with fetch_ready held: first cycle invalid, then 0,4,8,12
    reset_n = 1'b1;
    fetch_ready = 1'b1;
    check("first_cycle_valid", 32'(pc_valid), 32'(0));
    repeat (4) tick();
    check("seq_pc12", pc_out, 32'd12);

    // Taken BEQ, accepted together with fetch_ready: target wins
    branch(F3_BEQ, 32'd5, 32'd5, 32'h40, 13'h010);
    check("beq_flush", 32'(flush), 32'(1));
    repeat (FC) tick();
    check("beq_target", pc_out, 32'h50);
    check("beq_valid", 32'(pc_valid), 32'(1));

    // Backward signed-taken BLT, then unsigned-untaken BLTU
    branch(F3_BLT, 32'hFFFF_FFFF, 32'd1, 32'h100, 13'h1FF0);
    repeat (FC) tick();
    check("blt_target", pc_out, 32'hF0);
    branch(F3_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h100, 13'h1FF0);
    check("bltu_no_flush", 32'(flush), 32'(0));
    check("bltu_pc", pc_out, 32'hF4);
    tick();

    // Misaligned target trap and acknowledge
    branch(F3_BNE, 32'd1, 32'd2, 32'h200, 13'h006);
    check("mis_pulse", 32'(misaligned_trap), 32'(1));
    check("mis_trap_pc", trap_pc, 32'h200);
    repeat (3) tick();
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    check("trap_vec", pc_out, 32'h100);
    check("trap_valid", 32'(pc_valid), 32'(1));
    tick();

    // Wrap from FFFF_FFFC to 0
    branch(F3_BEQ, 32'd0, 32'd0, 32'h0, 13'h1FFC);
    repeat (FC) tick();
    check("wrap_pre", pc_out, 32'hFFFF_FFFC);
    tick();
    check("wrap_post", pc_out, 32'h0);

    // Reserved funct3 010 is never taken
    branch(3'b010, 32'd7, 32'd7, 32'h0, 13'h010);
    check("f3_010_flush", 32'(flush), 32'(0));

    // Reset during the first FLUSH cycle
    branch(F3_BEQ, 32'd1, 32'd1, 32'h80, 13'h020);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("midflush_state", 32'(dut.state_q), 32'(IDLE));
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (3) tick();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      br_valid = ($urandom % 2) == 1;
      br_funct3 = 3'($urandom);
      br_rs1 = $urandom;
      br_rs2 = (($urandom % 4) == 0) ? br_rs1 : $urandom;
      br_pc = $urandom & 32'hFFFF_FFFC;
      immediate_branch_in = 13'($urandom);
      fetch_ready = ($urandom % 4) != 0;
      trap_ack = ($urandom % 3) == 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
